// File: rtl/muldiv_sched_if.sv
// HI/LO sequencing bus: EX-side request/stall/result signals plus the
// multiplier and divider side-band. The controller uses the slave modport;
// the EX stage / datapath side uses the master modport.
interface muldiv_sched_if;
  logic        md_valid_i;
  logic [2:0]  md_op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        flush_i;
  logic [31:0] mul_a_o;
  logic [31:0] mul_b_o;
  logic        mul_signed_o;
  logic [63:0] mul_product_i;
  logic        div_start_o;
  logic        div_annul_o;
  logic        div_signed_o;
  logic [31:0] div_a_o;
  logic [31:0] div_b_o;
  logic        div_ready_i;
  logic [63:0] div_result_i;
  logic        stall_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport slave (
    input  md_valid_i, md_op_i, a_i, b_i, flush_i,
    input  mul_product_i, div_ready_i, div_result_i,
    output mul_a_o, mul_b_o, mul_signed_o,
    output div_start_o, div_annul_o, div_signed_o, div_a_o, div_b_o,
    output stall_o, hi_o, lo_o
  );

  modport master (
    output md_valid_i, md_op_i, a_i, b_i, flush_i,
    output mul_product_i, div_ready_i, div_result_i,
    input  mul_a_o, mul_b_o, mul_signed_o,
    input  div_start_o, div_annul_o, div_signed_o, div_a_o, div_b_o,
    input  stall_o, hi_o, lo_o
  );
endinterface

// File: rtl/muldiv_sched.sv
// muldiv_sched: EX-stage HI/LO sequencing controller.
// Starts the external multiplier (fixed MUL_CYCLES latency) and iterative
// divider, stalls the pipeline while they run, handles flush/annul and owns
// the architectural HI/LO registers.
// Optional build macro DIV_ZERO_FAST_EN: divide by zero bypasses the divider
// and commits HI=dividend, LO=all ones directly from IDLE.
module muldiv_sched #(
  parameter int MUL_CYCLES = 2
) (
  input logic          clk,
  input logic          rst,
  muldiv_sched_if.slave bus
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  // Count value on which the multiplier product is taken.
  localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    DIV_BUSY = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic [3:0]  count_r, count_s;
  logic [31:0] op_a_r, op_a_s;
  logic [31:0] op_b_r, op_b_s;
  logic        sign_r, sign_s;
  logic [31:0] hi_r, hi_s;
  logic [31:0] lo_r, lo_s;
  logic        stall_s;
  logic        start_s;
  logic        annul_s;

  // Signed variants are the odd encodings of each multiply/divide pair.
  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  // Next-state, datapath-update and handshake decode for the sequencer.
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    op_a_s  = op_a_r;
    op_b_s  = op_b_r;
    sign_s  = sign_r;
    hi_s    = hi_r;
    lo_s    = lo_r;
    stall_s = 1'b0;
    start_s = 1'b0;
    annul_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.md_valid_i && !bus.flush_i) begin
          case (bus.md_op_i)
            OP_MULT, OP_MULTU: begin
              stall_s = 1'b1;
              op_a_s  = bus.a_i;
              op_b_s  = bus.b_i;
              sign_s  = op_is_signed(bus.md_op_i);
              count_s = 4'd0;
              state_s = MUL_BUSY;
            end
            OP_DIV, OP_DIVU: begin
              stall_s = 1'b1;
              op_a_s  = bus.a_i;
              op_b_s  = bus.b_i;
              sign_s  = op_is_signed(bus.md_op_i);
`ifdef DIV_ZERO_FAST_EN
              if (bus.b_i == 32'd0) begin
                hi_s    = bus.a_i;
                lo_s    = 32'hFFFF_FFFF;
                state_s = DONE;
              end else begin
                state_s = DIV_BUSY;
              end
`else
              state_s = DIV_BUSY;
`endif
            end
            OP_MTHI: begin
              hi_s = bus.a_i;
            end
            OP_MTLO: begin
              lo_s = bus.a_i;
            end
            default: begin
              state_s = IDLE;
            end
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      MUL_BUSY: begin
        if (bus.flush_i) begin
          state_s = IDLE;
        end else begin
          stall_s = 1'b1;
          count_s = count_r + 4'd1;
          if (count_r == MUL_LAST) begin
            hi_s    = bus.mul_product_i[63:32];
            lo_s    = bus.mul_product_i[31:0];
            state_s = DONE;
          end else begin
            state_s = MUL_BUSY;
          end
        end
      end
      DIV_BUSY: begin
        if (bus.flush_i) begin
          annul_s = 1'b1;
          state_s = IDLE;
        end else begin
          stall_s = 1'b1;
          start_s = 1'b1;
          if (bus.div_ready_i) begin
            hi_s    = bus.div_result_i[63:32];
            lo_s    = bus.div_result_i[31:0];
            state_s = DONE;
          end else begin
            state_s = DIV_BUSY;
          end
        end
      end
      DONE: begin
        // Same instruction is still presented: never re-issue it.
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, operand latches and HI/LO registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      count_r <= 4'd0;
      op_a_r  <= 32'd0;
      op_b_r  <= 32'd0;
      sign_r  <= 1'b0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      op_a_r  <= op_a_s;
      op_b_r  <= op_b_s;
      sign_r  <= sign_s;
      hi_r    <= hi_s;
      lo_r    <= lo_s;
    end
  end

  // The divider shares rst, so no start/annul is signalled while resetting.
  assign bus.div_start_o  = start_s & ~rst;
  assign bus.div_annul_o  = annul_s & ~rst;
  assign bus.stall_o      = stall_s;
  assign bus.mul_a_o      = op_a_r;
  assign bus.mul_b_o      = op_b_r;
  assign bus.mul_signed_o = sign_r;
  assign bus.div_a_o      = op_a_r;
  assign bus.div_b_o      = op_b_r;
  assign bus.div_signed_o = sign_r;
  assign bus.hi_o         = hi_r;
  assign bus.lo_o         = lo_r;

endmodule

// File: tb/tb_muldiv_sched.sv
// Self-checking bench for muldiv_sched: behavioural multiplier/divider
// stubs plus an instruction-level reference model of stall length,
// divider start/annul activity, HI/LO and operand latches.
module tb_muldiv_sched;
  localparam int MC = 2;

  logic clk;
  logic rst;
  muldiv_sched_if bus();

  muldiv_sched #(.MUL_CYCLES(MC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int div_lat = 34;
  logic spur = 1'b0;
  int k = 0;

  // Reference model state
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;
  logic [31:0] exp_la = 32'd0;
  logic [31:0] exp_lb = 32'd0;
  logic        exp_sg = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mul_ref(input logic sg, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = sg ? longint'($signed(a)) : longint'({32'd0, a});
    sb = sg ? longint'($signed(b)) : longint'({32'd0, b});
    return 64'(sa * sb);
  endfunction

  // Returns {remainder, quotient}; divide by zero yields {a, all ones}.
  function automatic logic [63:0] div_ref(input logic sg, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sg) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      sa = int'(a);
      sb = int'(b);
      q = sa / sb;
      r = sa % sb;
      return {32'(r), 32'(q)};
    end
    return {a % b, a / b};
  endfunction

  // Multiplier stub: product follows the latched operands.
  assign bus.mul_product_i = mul_ref(bus.mul_signed_o, bus.mul_a_o, bus.mul_b_o);

  // Divider stub: ready in the div_lat-th consecutive start cycle.
  always @(posedge clk) begin
    if (rst || !bus.div_start_o) k <= 0;
    else k <= k + 1;
  end
  assign bus.div_ready_i  = (bus.div_start_o && (k == div_lat - 1)) || spur;
  assign bus.div_result_i = div_ref(bus.div_signed_o, bus.div_a_o, bus.div_b_o);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Present one EX instruction until it leaves EX and compare with the model.
  // flush_at: cycle index (0 = first cycle presented) carrying flush_i, -1 none.
  task automatic run_instr(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int flush_at, input int lat);
    int c, n_stall, n_start, n_annul, n_busy;
    int e_stall, e_start, e_annul;
    bit is_md, is_div, fz, done_flag;
    logic [63:0] res;
`ifdef DIV_ZERO_FAST_EN
    fz = 1'b1;
`else
    fz = 1'b0;
`endif
    is_md  = (op >= 3'd1) && (op <= 3'd4);
    is_div = (op == 3'd3) || (op == 3'd4);
    n_busy = !is_md ? 0 : !is_div ? MC : (fz && b == 32'd0) ? 0 : lat;
    e_stall = 0; e_start = 0; e_annul = 0;
    if (flush_at == 0) begin
      // cancelled before it started: nothing happens
    end else if (is_md && flush_at >= 1 && flush_at <= n_busy) begin
      e_stall = flush_at;
      e_start = is_div ? flush_at - 1 : 0;
      e_annul = is_div ? 1 : 0;
      exp_la = a; exp_lb = b; exp_sg = (op == 3'd1) || (op == 3'd3);
    end else begin
      if (is_md) begin
        e_stall = n_busy + 1;
        e_start = is_div ? n_busy : 0;
        exp_la = a; exp_lb = b; exp_sg = (op == 3'd1) || (op == 3'd3);
        res = is_div ? div_ref(exp_sg, a, b) : mul_ref(exp_sg, a, b);
        exp_hi = res[63:32];
        exp_lo = res[31:0];
      end else if (op == 3'd5) begin
        exp_hi = a;
      end else if (op == 3'd6) begin
        exp_lo = a;
      end
    end

    div_lat = lat;
    bus.md_valid_i = 1'b1;
    bus.md_op_i = op;
    bus.a_i = a;
    bus.b_i = b;
    c = 0; n_stall = 0; n_start = 0; n_annul = 0; done_flag = 1'b0;
    while (!done_flag && c < 200) begin
      bus.flush_i = (c == flush_at);
      @(negedge clk);
      if (bus.stall_o) n_stall++;
      if (bus.div_start_o) n_start++;
      if (bus.div_annul_o) n_annul++;
      if (!bus.stall_o) done_flag = 1'b1;
      @(posedge clk);
      #1;
      c++;
    end
    bus.md_valid_i = 1'b0;
    bus.md_op_i = 3'd0;
    bus.flush_i = 1'b0;
    chk($sformatf("op%0d_released", op), 64'(done_flag), 64'd1);
    chk($sformatf("op%0d_stall_cycles", op), 64'(n_stall), 64'(e_stall));
    chk($sformatf("op%0d_start_cycles", op), 64'(n_start), 64'(e_start));
    chk($sformatf("op%0d_annul_pulses", op), 64'(n_annul), 64'(e_annul));
    chk($sformatf("op%0d_hi", op), 64'(bus.hi_o), 64'(exp_hi));
    chk($sformatf("op%0d_lo", op), 64'(bus.lo_o), 64'(exp_lo));
    chk($sformatf("op%0d_lat_a", op), 64'(bus.mul_a_o), 64'(exp_la));
    chk($sformatf("op%0d_lat_b", op), 64'(bus.div_b_o), 64'(exp_lb));
    chk($sformatf("op%0d_lat_sign", op), 64'({bus.mul_signed_o, bus.div_signed_o}), 64'({exp_sg, exp_sg}));
  endtask

  initial begin
    int op, fa, lat;
    logic [31:0] ra, rb;
    bus.md_valid_i = 1'b0;
    bus.md_op_i = 3'd0;
    bus.a_i = 32'd0;
    bus.b_i = 32'd0;
    bus.flush_i = 1'b0;

    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_hi", 64'(bus.hi_o), 64'd0);
    chk("rst_lo", 64'(bus.lo_o), 64'd0);
    chk("rst_stall", 64'(bus.stall_o), 64'd0);
    chk("rst_div_start", 64'(bus.div_start_o), 64'd0);
    chk("rst_lat_a", 64'(bus.div_a_o), 64'd0);
    @(posedge clk);
    #1;

    // Directed cases from the plan
    run_instr(3'd1, 32'hFFFF_FFFE, 32'd3, -1, 34);      // MULT -2*3
    run_instr(3'd4, 32'd100, 32'd7, -1, 34);            // DIVU 100/7
    run_instr(3'd3, 32'hFFFF_FFF9, 32'd2, 10, 34);      // DIV flushed in cycle 10
    run_instr(3'd6, 32'd5, 32'd0, -1, 34);              // MTLO 5
    run_instr(3'd5, 32'h1234_5678, 32'd0, -1, 34);      // MTHI
    run_instr(3'd6, 32'h9ABC_DEF0, 32'd0, -1, 34);      // MTLO back-to-back
    run_instr(3'd3, 32'd9, 32'd0, -1, 34);              // DIV by zero

    // Boundaries: flush in DONE, in IDLE, on completion, on ready
    run_instr(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MC + 1, 8);
    run_instr(3'd4, 32'd77, 32'd3, 0, 8);
    run_instr(3'd1, 32'd1234, 32'd5678, MC, 8);
    run_instr(3'd3, 32'h8000_0000, 32'd3, 5, 5);
    run_instr(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1);

    // Spurious divider ready outside DIV_BUSY
    spur = 1'b1;
    run_instr(3'd5, 32'hCAFE_F00D, 32'd0, -1, 8);
    run_instr(3'd1, 32'h7FFF_FFFF, 32'h8000_0000, -1, 8);
    run_instr(3'd0, 32'h1111_1111, 32'd1, -1, 8);
    spur = 1'b0;

    // Reset in the middle of a divide
    div_lat = 30;
    bus.md_valid_i = 1'b1;
    bus.md_op_i = 3'd4;
    bus.a_i = 32'd50;
    bus.b_i = 32'd6;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_annul", 64'(bus.div_annul_o), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.md_valid_i = 1'b0;
    bus.md_op_i = 3'd0;
    @(negedge clk);
    chk("rstmid_hi", 64'(bus.hi_o), 64'd0);
    chk("rstmid_lo", 64'(bus.lo_o), 64'd0);
    chk("rstmid_start", 64'(bus.div_start_o), 64'd0);
    chk("rstmid_stall", 64'(bus.stall_o), 64'd0);
    @(posedge clk);
    #1;
    exp_hi = 32'd0; exp_lo = 32'd0; exp_la = 32'd0; exp_lb = 32'd0; exp_sg = 1'b0;
    run_instr(3'd3, 32'hFFFF_FF9C, 32'd7, -1, 3);       // DIV -100/7 after reset

    // Randomised instruction stream
    for (int i = 0; i < 60; i++) begin
      op  = int'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      lat = int'($urandom_range(1, 40));
      fa  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 42)) : -1;
      run_instr(3'(op), ra, rb, fa, lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
